// File: rtl/det_log_pkg.sv
// Shared defaults for the detect event logger: timestamp width, FIFO depth and pointer width.
package det_log_pkg;

    localparam int TS_W_DEF  = 8;
    localparam int DEPTH_DEF = 4;
    localparam int PTR_W_DEF = $clog2(DEPTH_DEF);

    // Pointer width for a power-of-two depth of at least 2.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/det_log_fifo.sv
// Show-ahead event FIFO for the detect event logger: storage, wrapping pointers and occupancy.
// A push into a full FIFO is accepted only when a pop frees the head on the same edge.
module det_log_fifo
    import det_log_pkg::*;
#(
    parameter int W     = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        push,
    input  logic                        pop,
    input  logic [W-1:0]                wdata,
    output logic [W-1:0]                rdata,
    output logic                        valid,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        drop
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam logic [PTR_W:0] LEVEL_FULL = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   level_q, level_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic [W-1:0]     mem_d [DEPTH];

    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    always_comb begin
        empty   = (level_q == '0);
        full    = (level_q == LEVEL_FULL);
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        drop    = push & full & ~do_pop & ~clr;

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        mem_d    = mem_q;

        // Clear wins over any same-edge push or pop; contents need not be wiped.
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = wdata;
                wr_ptr_d        = wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            mem_q    <= mem_d;
        end
    end

    assign valid = ~empty;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];
    assign level = level_q;

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps detector match pulses and queues them in a show-ahead FIFO with sticky overflow.
// Optional macro DET_LOG_DROP_CNT_EN adds an 8-bit saturating count of dropped events (drop_cnt).
module detect_event_logger
    import det_log_pkg::*;
#(
    parameter int TS_W  = TS_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        det_in,
    input  logic                        clr,
    output logic                        ev_valid,
    input  logic                        ev_ready,
    output logic [TS_W-1:0]             ev_ts,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        ovf
`ifdef DET_LOG_DROP_CNT_EN
    ,
    output logic [7:0]                  drop_cnt
`endif
);

    logic [TS_W-1:0] ts_q, ts_d;
    logic            ovf_q, ovf_d;
    logic            fifo_drop;

    // The FIFO stores the timestamp as it stood before this edge's increment.
    det_log_fifo #(
        .W     (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (det_in),
        .pop   (ev_ready),
        .wdata (ts_q),
        .rdata (ev_ts),
        .valid (ev_valid),
        .level (level),
        .drop  (fifo_drop)
    );

    always_comb begin
        ts_d  = ts_q + 1'b1;
        ovf_d = ovf_q | fifo_drop;
        if (clr) begin
            ts_d  = '0;
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q  <= '0;
            ovf_q <= 1'b0;
        end else begin
            ts_q  <= ts_d;
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;

`ifdef DET_LOG_DROP_CNT_EN
    logic [7:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (clr) begin
            drop_cnt_d = '0;
        end else if (fifo_drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_detect_event_logger.sv
// Randomized plus directed bench for detect_event_logger with a queue-based reference model.
module tb_detect_event_logger;

    localparam int TS_W  = 8;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic                   det_in;
    logic                   clr;
    logic                   ev_valid;
    logic                   ev_ready;
    logic [TS_W-1:0]        ev_ts;
    logic [$clog2(DEPTH):0] level;
    logic                   ovf;
`ifdef DET_LOG_DROP_CNT_EN
    logic [7:0]             drop_cnt;
`endif

    detect_event_logger #(.TS_W(TS_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .det_in   (det_in),
        .clr      (clr),
        .ev_valid (ev_valid),
        .ev_ready (ev_ready),
        .ev_ts    (ev_ts),
        .level    (level),
        .ovf      (ovf)
`ifdef DET_LOG_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit run    = 0;

    // Reference model: timestamp as a plain integer, queue of accepted timestamps.
    int exp_q[$];
    int mlevel = 0;
    int mts    = 0;
    int movf   = 0;
    int mdrop  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mlevel = 0;
        mts    = 0;
        movf   = 0;
        mdrop  = 0;
    endtask

    task automatic model_edge(input bit d, input bit r, input bit c);
        bit pop_m;
        bit push_m;
        if (c) begin
            model_reset();
        end else begin
            pop_m  = r && (mlevel > 0);
            push_m = d && ((mlevel < DEPTH) || pop_m);
            if (push_m) exp_q.push_back(mts);
            if (d && !push_m) begin
                movf = 1;
                if (mdrop < 255) mdrop++;
            end
            mlevel = mlevel + int'(push_m) - int'(pop_m);
            mts = (mts + 1) % (1 << TS_W);
        end
    endtask

    // Inputs change 1 time unit after a rising edge; the model advances on the edge.
    task automatic step(input bit d, input bit r, input bit c);
        det_in   = d;
        ev_ready = r;
        clr      = c;
        @(posedge clk);
        model_edge(d, r, c);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        #1;
        check("rst_level", 32'(level), 0);
        check("rst_valid", 32'(ev_valid), 0);
        check("rst_ts", 32'(ev_ts), 0);
        check("rst_ovf", 32'(ovf), 0);
`ifdef DET_LOG_DROP_CNT_EN
        check("rst_drop_cnt", 32'(drop_cnt), 0);
`endif
        model_reset();
        rst = 1'b0;
    endtask

    task automatic clr_and_idle(input int n);
        step(0, 0, 1);
        for (int i = 0; i < n; i++) step(0, 0, 0);
    endtask

    // Monitor: compares occupancy every cycle and the head on every handshake.
    always @(negedge clk) begin
        if (run && !rst) begin
            check("level", 32'(level), 32'(mlevel));
            check("valid", 32'(ev_valid), 32'(mlevel != 0));
            check("ovf", 32'(ovf), 32'(movf));
`ifdef DET_LOG_DROP_CNT_EN
            check("drop_cnt", 32'(drop_cnt), 32'(mdrop));
`endif
            if (ev_valid && ev_ready && !clr) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL head: got handshake ts %0d expected no event", ev_ts);
                end else begin
                    check("head_ts", 32'(ev_ts), 32'(exp_q.pop_front()));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy_pct;
        rst = 1'b1; det_in = 1'b0; ev_ready = 1'b0; clr = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("por_level", 32'(level), 0);
        check("por_valid", 32'(ev_valid), 0);
        check("por_ts", 32'(ev_ts), 0);
        check("por_ovf", 32'(ovf), 0);
        rst = 1'b0;
        model_reset();
        run = 1;

        // First event on the third edge after reset carries ts 2.
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        check("s1_valid", 32'(ev_valid), 1);
        check("s1_ts", 32'(ev_ts), 2);
        check("s1_level", 32'(level), 1);

        // Five events from ts 10 into a stalled FIFO: one dropped.
        clr_and_idle(10);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        check("s2_level", 32'(level), 4);
        check("s2_ovf", 32'(ovf), 1);
`ifdef DET_LOG_DROP_CNT_EN
        check("s2_drop_cnt", 32'(drop_cnt), 1);
`endif
        for (int i = 0; i < 4; i++) begin
            check("s2_drain", 32'(ev_ts), 32'(10 + i));
            step(0, 1, 0);
        end
        check("s2_empty", 32'(ev_valid), 0);

        // Full FIFO with same-edge push and pop.
        clr_and_idle(0);
        for (int i = 0; i < 4; i++) step(1, 0, 0);
        step(1, 1, 0);
        check("s3_level", 32'(level), 4);
        check("s3_ovf", 32'(ovf), 0);
        for (int i = 0; i < 4; i++) begin
            check("s3_drain", 32'(ev_ts), 32'(1 + i));
            step(0, 1, 0);
        end

        // Timestamp wrap.
        clr_and_idle(255);
        step(1, 0, 0);
        step(1, 0, 0);
        check("s4_head", 32'(ev_ts), 255);
        step(0, 1, 0);
        check("s4_next", 32'(ev_ts), 0);
        step(0, 1, 0);

        // Asynchronous reset discards queued events.
        clr_and_idle(2);
        for (int i = 0; i < 3; i++) step(1, 0, 0);
        do_rst();
        step(1, 0, 0);
        check("s5_ts", 32'(ev_ts), 0);
        check("s5_level", 32'(level), 1);

        // Clear beats a same-edge push.
        clr_and_idle(0);
        for (int i = 0; i < 5; i++) step(1, 0, 0);
        step(0, 1, 0);
        step(0, 1, 0);
        check("s6_pre_level", 32'(level), 2);
        step(1, 0, 1);
        check("s6_level", 32'(level), 0);
        check("s6_ovf", 32'(ovf), 0);
        step(1, 0, 0);
        check("s6_ts", 32'(ev_ts), 0);

        // Random traffic with changing consumer throughput.
        rdy_pct = 50;
        for (int n = 0; n < 3000; n++) begin
            int r;
            if (n % 200 == 0) rdy_pct = $urandom_range(0, 2) * 40 + 10;
            r = $urandom_range(0, 199);
            if (r == 0) begin
                do_rst();
            end else begin
                step(1'($urandom_range(0, 1)), ($urandom_range(0, 99) < rdy_pct), (r < 4));
            end
        end

        step(0, 0, 0);
        @(negedge clk);
        #1;
        run = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
